// File: rtl/spi_cmd_master.sv
// spi_cmd_master: queues 24-bit command frames and ships each one as an SPI mode-0
// transaction (CPOL=0, MSB first), returning the 24-bit MISO word with a rsp_valid pulse.
// Optional build macro SPI_CMD_MASTER_FIFO_EN: command store becomes a FIFO_DEPTH-entry
// FIFO that keeps accepting while a frame is in flight; otherwise a single holding
// register that only accepts in IDLE.
module spi_cmd_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [23:0] cmd_data,
  output logic        cmd_ready,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        rsp_valid,
  output logic [23:0] rsp_data,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;      // SCK falling edges completed in this frame
  logic [23:0] tx_q, tx_d;
  logic [23:0] rx_q, rx_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [23:0] rsp_data_q, rsp_data_d;

  logic        half_done;
  logic        push, pop;
  logic        store_empty;
  logic [23:0] store_word;

  assign half_done = (cnt_q == 8'(CLK_DIV - 1));
  assign push      = cmd_valid && cmd_ready;

`ifdef SPI_CMD_MASTER_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  assign store_empty = (count_q == '0);
  assign store_word  = mem_q[rd_ptr_q];
  assign cmd_ready   = (count_q != (AW+1)'(FIFO_DEPTH));

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array is deliberately not reset; entries are never read before
  // being written, so only the pointers and count need a reset value.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_data;
  end
`else
  logic [23:0] hold_q;
  logic        hold_valid_q;

  assign store_empty = !hold_valid_q;
  assign store_word  = hold_q;
  assign cmd_ready   = (state_q == S_IDLE) && !hold_valid_q;

  // Single holding register: filled by an accepted push, emptied when IDLE pops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (push) begin
      hold_q       <= cmd_data;
      hold_valid_q <= 1'b1;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  // Next-state and registered-output logic of the frame sequencer.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    pop         = 1'b0;

    if (state_q != S_IDLE) cnt_d = half_done ? 8'd0 : cnt_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        sck_d  = 1'b0;
        if (!store_empty) begin
          pop     = 1'b1;
          tx_d    = store_word;
          mosi_d  = store_word[23];
          cs_n_d  = 1'b0;
          bit_d   = 5'd0;
          cnt_d   = 8'd0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (half_done) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[22:0], spi_miso};
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (half_done) begin
          if (sck_q) begin
            // Falling edge: present the next bit; the last bit stays on the line.
            sck_d = 1'b0;
            bit_d = bit_q + 5'd1;
            if (bit_q != 5'd23) begin
              tx_d   = {tx_q[22:0], 1'b0};
              mosi_d = tx_q[22];
            end
          end else if (bit_q == 5'd24) begin
            state_d = S_HOLD;
          end else begin
            sck_d = 1'b1;
            rx_d  = {rx_q[22:0], spi_miso};
          end
        end
      end
      S_HOLD: begin
        if (half_done) begin
          cs_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (half_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame without a response pulse.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign spi_cs_n  = cs_n_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE) || !store_empty;

endmodule

// File: doc/spi_cmd_master.md
SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL be:
- CLK_DIV, default 4: SCK half-period in clk cycles, legal range 2..255.
- FIFO_DEPTH, default 4: command FIFO entries, power of two, 2..16.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command word offered.
- cmd_data  in  24  frame to send: {command[23:16], address[15:8], data[7:0]}.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- spi_cs_n  out  1  active-low chip select.
- spi_sck  out  1  SPI clock, CPOL=0.
- spi_mosi  out  1  serial data out, MSB first.
- spi_miso  in  1  serial data in, MSB first.
- rsp_valid  out  1  one-cycle pulse: rsp_data holds a completed frame.
- rsp_data  out  24  last received 24-bit MISO frame.
- busy  out  1  high while a frame is in flight or the command store is non-empty.

Function
REQ-004 SPI mode 0 SHALL be used: MOSI is driven before each SCK rising edge, MISO is sampled on each SCK rising edge, and MOSI changes only on SCK falling edges or at CS assertion.
REQ-005 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-006 Each non-IDLE state SHALL use a half-period counter that counts CLK_DIV clk cycles.
REQ-007 IDLE SHALL behave as follows:
- On a non-empty command store, pop one word into the shift register, drive spi_cs_n=0 and spi_mosi=bit23, then go to SETUP.
- Otherwise hold spi_cs_n=1 and spi_sck=0.
REQ-008 SETUP SHALL wait CLK_DIV cycles, then go to SHIFT.
REQ-009 SHIFT SHALL generate 24 SCK periods, each CLK_DIV cycles high then CLK_DIV cycles low:
- Rising edge: shift spi_miso into the receive register.
- Falling edge: advance spi_mosi to the next bit.
- After the 24th falling edge, go to HOLD.
REQ-010 HOLD SHALL keep spi_cs_n low for CLK_DIV cycles, then:
- drive spi_cs_n=1,
- load rsp_data and pulse rsp_valid for exactly one cycle,
- go to GAP.
REQ-011 GAP SHALL keep spi_cs_n high for CLK_DIV cycles, then go to IDLE; back-to-back commands are therefore separated by at least CLK_DIV cycles of CS high.
REQ-012 A frame SHALL last 2+2*24 = 50 half-periods from CS fall to CS rise (200 clk cycles at CLK_DIV=4).
REQ-013 cmd_ready SHALL equal "command store not full"; a push and a pop in the same cycle SHALL both take effect with no loss or duplication.
REQ-014 cmd_valid while cmd_ready=0 SHALL be ignored, and the word SHALL NOT be stored.
REQ-015 spi_sck SHALL be 0 whenever spi_cs_n=1.
REQ-016 spi_mosi SHALL hold its last value outside frames.
REQ-017 busy SHALL be 1 from the cycle after an accepted push until GAP ends with the store empty.

Reset
REQ-018 Reset SHALL override all other activity, including mid-frame, and force:
- FSM to IDLE, counters cleared, command store emptied;
- spi_cs_n=1, spi_sck=0, spi_mosi=0;
- rsp_valid=0, rsp_data=0, busy=0, cmd_ready=1.
REQ-019 A frame cut short by reset SHALL produce no rsp_valid pulse.
REQ-020 In the first cycle after reset deasserts, spi_cs_n SHALL be 1.

Configuration
REQ-021 With macro SPI_CMD_MASTER_FIFO_EN defined, the command store SHALL be a FIFO_DEPTH-entry FIFO, and commands SHALL be accepted while a frame is in flight.
REQ-022 With SPI_CMD_MASTER_FIFO_EN undefined:
- the command store SHALL be a single holding register;
- cmd_ready SHALL be 1 only in IDLE with the register empty;
- FIFO_DEPTH SHALL be ignored.

Verification
REQ-023 Single frame: CLK_DIV=4, push 24'h20A55A with spi_miso tied to a slave model returning 24'hFF0000 -> slave captures 24'h20A55A; 24 SCK rises; CS low for 200 cycles; rsp_valid pulses once with rsp_data=24'hFF0000.
REQ-024 Back-to-back: push 24'hFD0000, 24'h200102, 24'hFE0000 in three consecutive cycles (FIFO_EN) -> three frames in order; CS high at least 4 cycles between frames; busy falls after the third GAP.
REQ-025 Full FIFO: FIFO_DEPTH=4, hold cmd_valid with 6 distinct words while the first frame is in flight -> cmd_ready deasserts after 5 accepts (one in shift register, 4 queued); exactly those 5 transmitted, in order.
REQ-026 Reset mid-frame: assert reset at SCK rise 10 of a frame -> next cycle spi_cs_n=1, spi_sck=0, busy=0; no rsp_valid; the next push yields a clean 24-bit frame.
REQ-027 Non-FIFO build: SPI_CMD_MASTER_FIFO_EN undefined, push 24'h200001 then attempt 24'h200002 during the frame -> second word refused until IDLE; accepted afterwards and sent.
REQ-028 Divider corner: CLK_DIV=2, push 24'h800001 -> SCK period 4 clk cycles; MOSI stable 2 cycles before each rise; frame 100 cycles CS low.
